ap_out_collector: RTL and testbench
===================================

Name: ap_out_collector

Overview:
- Consumer end of the arithmetic part's result interface. Takes the packed per-core result bus (`out`) and per-core strobes (`out_en`) from the arithmetic part.
- Buffers each strobed result vector in a small FIFO, then serializes the valid bytes one per cycle onto a valid/ready write port toward the output feature-map memory.
- Keeps one pixel-address counter per core (per output channel), so the memory side receives {core id, address, data} for every result.

Parameters:
- outport, 8, bits per core result
- N_core, 8, number of arithmetic cores / output channels
- core_bit, 3, width of core index; must be at least clog2(N_core)
- depth, 4, capture FIFO entries; power of two, at least 2
- addr_bit, 16, width of the per-core pixel address counters

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- start  input  1  begin new layer: flush FIFO, clear address counters and overflow
- in  input  outport*N_core  result bus; core i occupies [outport*N_core-i*outport-1 -: outport] (core 0 = MSB slice)
- in_en  input  N_core  result strobes; core i is bit N_core-1-i
- wr_valid  output  1  write request valid
- wr_ready  input  1  memory accepts write
- wr_data  output  outport  result byte
- wr_core  output  core_bit  core index of wr_data
- wr_addr  output  addr_bit  pixel address for that core
- busy  output  1  FIFO non-empty
- overflow  output  1  sticky: a capture was dropped

Behaviour:
- Reset: one clock, synchronous, active-high. All outputs are 0; FIFO is empty; address counters, pending mask and overflow are 0.
- Capture (push):
  - A push happens on any cycle with |in_en=1 and start=0; the entry stores {in, in_en}.
  - Cycles with in_en=0 push nothing.
  - A push is accepted when the FIFO is not full, or when the head entry retires in the same cycle.
  - Otherwise the entry is dropped and overflow is set to 1. overflow stays set until start or reset.
- Head serialization:
  - The head entry keeps a pending mask, initialised to its stored en.
  - The selected core i is the lowest index (MSB-side slice first) whose pending bit is set.
  - Outputs for the selected core: wr_valid=1, wr_data = slice i, wr_core = i, wr_addr = cnt[i].
- Transfer:
  - A transfer occurs on a clock edge with wr_valid & wr_ready.
  - On a transfer: clear pending bit i and increment cnt[i], wrapping mod 2^addr_bit.
  - When the last pending bit clears, the head retires (pop). The next head's first byte is presented the following cycle, with no bubble required beyond that.
- Latency: a strobe sampled at edge t with the FIFO empty gives wr_valid=1 in cycle t+1, since all outputs are registered. Peak throughput is one byte per cycle.
- Handshake stability: while wr_valid=1 and wr_ready=0, wr_data, wr_core and wr_addr must hold stable. wr_valid drops only after acceptance or on start/reset.
- start:
  - Takes effect at the edge where it is sampled high; it flushes the FIFO and clears counters and overflow.
  - wr_valid=0 from the next cycle. Any in_en in the same cycle is ignored and does not set overflow.
  - A transfer that completes in the same cycle as start is discarded; its counter increment is lost because the counter is cleared.
- busy = FIFO count != 0.
- Counters are independent per core. Wrap from 2^addr_bit-1 to 0 is silent.

Decomposition:
- Shared package: default widths (outport, N_core, core_bit, addr_bit, depth); slice-index helper function mapping core i to its bit range; FIFO entry width constant (outport*N_core + N_core).
- Sub-module ap_collect_fifo: synchronous FIFO with flush, full/empty, and simultaneous push/pop. It holds the entry storage.
- The serializer, pending mask, address counters and overflow logic live in ap_out_collector.

Test Plan:
- Single capture: in_en=8'h80, slice0=0x5A, wr_ready=1 -> one cycle later wr_valid=1, wr_data=0x5A, wr_core=0, wr_addr=0. Then wr_valid=0 and busy=0.
- Full vector: in_en=8'hFF, slices 0x10..0x17 (core0..7), wr_ready=1 -> 8 consecutive transfers, cores 0..7, data 0x10..0x17, all addr 0. busy falls after the 8th.
- Backpressure: core 2 pending, wr_ready=0 for 5 cycles -> wr_valid/data/core/addr unchanged every cycle. Transfer completes on the first wr_ready=1 edge.
- Overflow: wr_ready=0, five strobes in_en=8'h01 -> first four accepted, fifth dropped, overflow=1. Releasing wr_ready gives exactly 4 transfers for core 7, addr 0..3.
- Address counting and start: three captures for core 3 -> wr_addr 0,1,2. Then start with an in_en pulse in the same cycle -> that pulse is ignored, overflow=0. The next capture for core 3 gives addr 0.
- Reset mid-drain: in_en=8'hFF, assert reset after 3 transfers -> next cycle wr_valid=0, busy=0. A new capture for core 0 gives addr 0.

Source files
------------

// File: rtl/ap_out_collector_pkg.sv
// Shared widths and slice helpers for the arithmetic-part result collector.
// Core 0 owns the MSB slice of the result bus and the MSB strobe bit.
package ap_out_collector_pkg;

  localparam int DEF_OUTPORT  = 8;
  localparam int DEF_N_CORE   = 8;
  localparam int DEF_CORE_BIT = 3;
  localparam int DEF_DEPTH    = 4;
  localparam int DEF_ADDR_BIT = 16;

  localparam int DEF_ENTRY_W =
    DEF_OUTPORT * DEF_N_CORE + DEF_N_CORE;

  function automatic int entry_w(
    input int w,
    input int n
  );
    return w * n + n;
  endfunction

  function automatic int slice_msb(
    input int i,
    input int w,
    input int n
  );
    return w * n - i * w - 1;
  endfunction

  function automatic int en_bit(
    input int i,
    input int n
  );
    return n - 1 - i;
  endfunction

endpackage

// File: rtl/ap_out_collector_if.sv
// Valid/ready write port toward the output feature-map memory.
// master = collector side, slave = memory side.
interface ap_out_collector_if
  import ap_out_collector_pkg::*;
#(
  parameter int outport  = DEF_OUTPORT,
  parameter int core_bit = DEF_CORE_BIT,
  parameter int addr_bit = DEF_ADDR_BIT
) ();

  logic                wr_valid;
  logic                wr_ready;
  logic [outport-1:0]  wr_data;
  logic [core_bit-1:0] wr_core;
  logic [addr_bit-1:0] wr_addr;

  modport master (
    output wr_valid,
    output wr_data,
    output wr_core,
    output wr_addr,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    input  wr_core,
    input  wr_addr,
    output wr_ready
  );

endinterface

// File: rtl/ap_collect_fifo.sv
// Capture FIFO for strobed result vectors; flush empties it in one edge.
// A push into a full FIFO is legal only when a pop happens on the same edge.
module ap_collect_fifo
  import ap_out_collector_pkg::*;
#(
  parameter int width = DEF_ENTRY_W,
  parameter int depth = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(depth);

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(depth));
  assign empty = (count == '0);

endmodule

// File: rtl/ap_out_collector.sv
// Collects per-core result strobes, buffers them, and serializes one byte
// per cycle with a per-core pixel address onto the memory write port.
module ap_out_collector
  import ap_out_collector_pkg::*;
#(
  parameter int outport  = DEF_OUTPORT,
  parameter int N_core   = DEF_N_CORE,
  parameter int core_bit = DEF_CORE_BIT,
  parameter int depth    = DEF_DEPTH,
  parameter int addr_bit = DEF_ADDR_BIT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [outport*N_core-1:0] in,
  input  logic [N_core-1:0]         in_en,
  ap_out_collector_if.master        wr,
  output logic                      busy,
  output logic                      overflow
);

  localparam int EW = entry_w(outport, N_core);
  localparam int DW = outport * N_core;

  logic [EW-1:0]       head;
  logic [DW-1:0]       head_data;
  logic [N_core-1:0]   head_en;
  logic                full;
  logic                empty;
  logic                valid;
  logic                push_req;
  logic                push_ok;
  logic                xfer;
  logic                pop;
  logic [N_core-1:0]   done;
  logic [N_core-1:0]   pend;
  logic [N_core-1:0]   sel_oh;
  logic [N_core-1:0]   rest;
  logic [core_bit-1:0] sel;
  logic [outport-1:0]  sel_data;
  logic [addr_bit-1:0] cnt [N_core];

  ap_collect_fifo #(
    .width (EW),
    .depth (depth)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (start),
    .push  (push_ok),
    .pop   (pop),
    .din   ({in, in_en}),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign head_data = head[EW-1:N_core];
  assign head_en   = head[N_core-1:0];
  assign valid     = !empty;

  // Bytes already sent from the head are masked out of its stored strobes.
  assign pend = valid ? (head_en & ~done) : '0;

  always_comb begin
    sel      = '0;
    sel_oh   = '0;
    sel_data = '0;
    for (int i = N_core - 1; i >= 0; i--) begin
      if (pend[en_bit(i, N_core)]) begin
        sel      = core_bit'(i);
        sel_oh   = '0;
        sel_oh[en_bit(i, N_core)] = 1'b1;
        sel_data = head_data[slice_msb(i, outport, N_core) -: outport];
      end
    end
  end

  assign xfer     = valid && wr.wr_ready;
  assign rest     = pend & ~sel_oh;
  assign pop      = xfer && (rest == '0) && !start;
  assign push_req = (|in_en) && !start;
  assign push_ok  = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (reset || start) begin
      done     <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < N_core; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      if (xfer) begin
        cnt[sel] <= cnt[sel] + addr_bit'(1);
        done     <= pop ? '0 : (done | sel_oh);
      end
      if (push_req && !push_ok) begin
        overflow <= 1'b1;
      end
    end
  end

  assign wr.wr_valid = valid;
  assign wr.wr_data  = sel_data;
  assign wr.wr_core  = sel;
  assign wr.wr_addr  = valid ? cnt[sel] : '0;
  assign busy        = valid;

endmodule

// File: tb/tb_ap_out_collector.sv
// Directed bench for ap_out_collector: capture, serialization,
// backpressure, overflow, address counting, start and reset.
module tb_ap_out_collector;
  import ap_out_collector_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] in_bus;
  logic [7:0]  in_en;
  logic        busy;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  ap_out_collector_if wr_if ();

  ap_out_collector dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in       (in_bus),
    .in_en    (in_en),
    .wr       (wr_if.master),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int core, input logic [7:0] v);
    in_bus[63-8*core -: 8] = v;
    in_en[7-core] = 1'b1;
  endtask

  task automatic chk_wr(
    input string tag,
    input int    core,
    input int    data,
    input int    addr
  );
    chk({tag, ".valid"}, 32'(wr_if.wr_valid), 1);
    chk({tag, ".core"},  32'(wr_if.wr_core),  32'(core));
    chk({tag, ".data"},  32'(wr_if.wr_data),  32'(data));
    chk({tag, ".addr"},  32'(wr_if.wr_addr),  32'(addr));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".valid"}, 32'(wr_if.wr_valid), 0);
    chk({tag, ".busy"},  32'(busy), 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    in_bus = '0;
    in_en = '0;
    wr_if.wr_ready = 1'b0;
    step();
    step();
    chk_idle("rst");
    chk("rst.data", 32'(wr_if.wr_data), 0);
    chk("rst.core", 32'(wr_if.wr_core), 0);
    chk("rst.addr", 32'(wr_if.wr_addr), 0);
    chk("rst.ovf",  32'(overflow), 0);
    reset = 1'b0;
    step();

    // single capture
    wr_if.wr_ready = 1'b1;
    put(0, 8'h5A);
    step();
    in_en = '0;
    chk_wr("single", 0, 'h5A, 0);
    step();
    chk_idle("single.after");

    // full vector, fresh counters
    do_start();
    in_en = '0;
    for (int k = 0; k < 8; k++) put(k, 8'(8'h10 + k));
    step();
    in_en = '0;
    for (int k = 0; k < 8; k++) begin
      chk_wr($sformatf("full%0d", k), k, 'h10 + k, 0);
      step();
    end
    chk_idle("full.after");

    // backpressure on core 2
    do_start();
    wr_if.wr_ready = 1'b0;
    put(2, 8'h33);
    step();
    in_en = '0;
    for (int k = 0; k < 5; k++) begin
      chk_wr($sformatf("bp%0d", k), 2, 'h33, 0);
      step();
    end
    wr_if.wr_ready = 1'b1;
    chk_wr("bp.rel", 2, 'h33, 0);
    step();
    chk_idle("bp.after");
    put(2, 8'h34);
    step();
    in_en = '0;
    chk_wr("bp.next", 2, 'h34, 1);
    step();

    // overflow: five strobes into a four-entry FIFO
    do_start();
    wr_if.wr_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      in_en = '0;
      put(7, 8'(8'hA0 + n));
      step();
      chk($sformatf("ovf.push%0d", n), 32'(overflow), 32'(n == 4));
    end
    in_en = '0;
    wr_if.wr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk_wr($sformatf("ovf.drain%0d", k), 7, 'hA0 + k, k);
      step();
    end
    chk_idle("ovf.after");
    chk("ovf.sticky", 32'(overflow), 1);

    // address counting, start clears overflow and ignores same-cycle strobe
    do_start();
    chk("adr.ovf_clr", 32'(overflow), 0);
    for (int k = 0; k < 3; k++) begin
      put(3, 8'(8'h30 + k));
      step();
      in_en = '0;
      chk_wr($sformatf("adr%0d", k), 3, 'h30 + k, k);
      step();
    end
    start = 1'b1;
    put(3, 8'h99);
    step();
    start = 1'b0;
    in_en = '0;
    chk_idle("adr.start");
    chk("adr.start_ovf", 32'(overflow), 0);
    put(3, 8'h44);
    step();
    in_en = '0;
    chk_wr("adr.restart", 3, 'h44, 0);
    step();

    // transfer coinciding with start is discarded
    put(3, 8'h55);
    step();
    in_en = '0;
    chk_wr("sx.pre", 3, 'h55, 1);
    do_start();
    chk_idle("sx.start");
    put(3, 8'h66);
    step();
    in_en = '0;
    chk_wr("sx.post", 3, 'h66, 0);
    step();

    // push into full FIFO accepted when head retires same edge
    do_start();
    wr_if.wr_ready = 1'b0;
    for (int n = 0; n < 4; n++) begin
      in_en = '0;
      put(7, 8'(8'hC0 + n));
      step();
    end
    in_en = '0;
    put(7, 8'hC4);
    wr_if.wr_ready = 1'b1;
    step();
    in_en = '0;
    chk("fp.ovf", 32'(overflow), 0);
    for (int k = 1; k < 5; k++) begin
      chk_wr($sformatf("fp%0d", k), 7, 'hC0 + k, k);
      step();
    end
    chk_idle("fp.after");

    // reset in the middle of a drain
    for (int k = 0; k < 8; k++) put(k, 8'(8'h20 + k));
    step();
    in_en = '0;
    for (int k = 0; k < 3; k++) begin
      chk_wr($sformatf("rmd%0d", k), k, 'h20 + k, 0);
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_idle("rmd.rst");
    put(0, 8'h77);
    step();
    in_en = '0;
    chk_wr("rmd.post", 0, 'h77, 0);
    step();
    chk_idle("rmd.after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
